// File: rtl/fp_acc.sv
// FP32 group accumulator: sums each group of acc_len_i products with RNE-rounded
// additions and hands one FP32 result per group to the downstream consumer.
module fp_acc #(
  parameter int unsigned AccLenWidth = 8,
  parameter int unsigned FpFormat    = 0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [31:0]            in_data_i,
  input  logic [AccLenWidth-1:0] acc_len_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [31:0]            out_data_o,
  output logic                   busy_o
);

  if (FpFormat != 0) begin : gen_fmt_check
    $error("fp_acc: only FP32 (FpFormat = 0) is supported");
  end

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    OUT
  } state_e;

  localparam logic [31:0] QNaN = 32'h7FC0_0000;

  // Single-cycle FP32 adder: align with guard/round/sticky, add, normalise, round to nearest even.
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y, res;
    logic        a_nan, b_nan, a_inf, b_inf, sub, round_up;
    logic [9:0]  ex, ey, diff, shamt, exp_n, exp_f;
    logic [26:0] sx, yfull, sy, lost, norm;
    logic [27:0] sum;
    logic [4:0]  lz;
    logic [32:0] rnd;
    a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    x = a;
    y = b;
    if (b[30:0] > a[30:0]) begin
      x = b;
      y = a;
    end
    ex    = (x[30:23] == 8'd0) ? 10'd1 : {2'b00, x[30:23]};
    ey    = (y[30:23] == 8'd0) ? 10'd1 : {2'b00, y[30:23]};
    sx    = {(x[30:23] != 8'd0), x[22:0], 3'b000};
    yfull = {(y[30:23] != 8'd0), y[22:0], 3'b000};
    diff  = ex - ey;
    lost  = yfull & ~({27{1'b1}} << diff[4:0]);
    if (diff >= 10'd27) begin
      sy = {26'd0, |yfull};
    end else begin
      sy = (yfull >> diff[4:0]) | {26'd0, |lost};
    end
    sub = x[31] ^ y[31];
    sum = sub ? ({1'b0, sx} - {1'b0, sy}) : ({1'b0, sx} + {1'b0, sy});
    lz  = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (sum[i]) lz = 5'(26 - i);
    end
    // Left shift is capped so the exponent bottoms out at 1 and the result lands subnormal.
    shamt = ({5'd0, lz} > (ex - 10'd1)) ? (ex - 10'd1) : {5'd0, lz};
    if (sum[27]) begin
      norm  = {sum[27:2], sum[1] | sum[0]};
      exp_n = ex + 10'd1;
    end else begin
      norm  = sum[26:0] << shamt;
      exp_n = ex - shamt;
    end
    exp_f    = norm[26] ? exp_n : 10'd0;
    round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    // Rounding carry ripples straight from the mantissa into the exponent field.
    rnd = {exp_f, norm[25:3]} + {32'd0, round_up};
    if (a_nan || b_nan) begin
      res = QNaN;
    end else if (a_inf && b_inf) begin
      res = (a[31] != b[31]) ? QNaN : a;
    end else if (a_inf) begin
      res = a;
    end else if (b_inf) begin
      res = b;
    end else if (sum == 28'd0) begin
      res = sub ? 32'd0 : {x[31], 31'd0};
    end else if (rnd[32:23] >= 10'd255) begin
      res = {x[31], 8'hFF, 23'd0};
    end else begin
      res = {x[31], rnd[30:0]};
    end
    return res;
  endfunction

  localparam logic [AccLenWidth-1:0] LenOne = AccLenWidth'(1);

  state_e                 state_q;
  logic [31:0]            acc_q, acc_d;
  logic [AccLenWidth-1:0] cnt_q, cnt_d, len_q, len_d;

  assign acc_d = fp_add(acc_q, in_data_i);
  assign cnt_d = cnt_q + LenOne;
  assign len_d = (acc_len_i == '0) ? LenOne : acc_len_i;

  // First beat loads the accumulator verbatim; later beats add into it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      acc_q   <= 32'd0;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            acc_q   <= in_data_i;
            len_q   <= len_d;
            cnt_q   <= LenOne;
            state_q <= (len_d == LenOne) ? OUT : ACC;
          end
        end
        ACC: begin
          if (in_valid_i) begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            if (cnt_d == len_q) state_q <= OUT;
          end
        end
        OUT: begin
          if (out_ready_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready_o  = (state_q != OUT);
  assign out_valid_o = (state_q == OUT);
  assign out_data_o  = (state_q == OUT) ? acc_q : 32'd0;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_fp_acc.sv
// Randomised and directed bench for fp_acc; expected sums come from an exact-integer
// FP32 reference that rounds the true sum of each pair to nearest even.
module tb_fp_acc;
  localparam int W = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_data;
  logic [W-1:0]  acc_len;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [31:0]   out_data;
  logic          busy;

  int            vecCount = 0;
  int            missCount = 0;
  int            rdyMode = 0;
  logic [31:0]   expQ[$];
  logic [31:0]   beatBuf [256];

  always #5 clk = ~clk;

  fp_acc #(.AccLenWidth(W)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (in_data),
    .acc_len_i  (acc_len),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (out_data),
    .busy_o     (busy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecCount++;
    if (got !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Exact reference: both operands become integers in units of 2^-149, then the sum is rounded.
  function automatic logic [299:0] toUnits(input logic [31:0] f);
    logic [299:0] sig;
    int sh;
    sig = (f[30:23] == 8'd0) ? 300'(f[22:0]) : 300'({1'b1, f[22:0]});
    sh  = (f[30:23] == 8'd0) ? 0 : int'(f[30:23]) - 1;
    return sig << sh;
  endfunction

  function automatic logic [31:0] refAdd(input logic [31:0] a, input logic [31:0] b);
    logic [299:0] ma, mb, mag, q, rem, half;
    logic neg;
    int p, sh;
    longint enc;
    bit aNan, bNan, aInf, bInf;
    aNan = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    bNan = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    aInf = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    bInf = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    if (aNan || bNan) return 32'h7FC00000;
    if (aInf && bInf) return (a[31] != b[31]) ? 32'h7FC00000 : a;
    if (aInf) return a;
    if (bInf) return b;
    ma = toUnits(a);
    mb = toUnits(b);
    if (a[31] == b[31]) begin
      mag = ma + mb;
      neg = a[31];
    end else if (ma >= mb) begin
      mag = ma - mb;
      neg = a[31];
    end else begin
      mag = mb - ma;
      neg = b[31];
    end
    if (mag == 0) return (a[31] && b[31]) ? 32'h80000000 : 32'h00000000;
    p = 0;
    for (int i = 0; i < 300; i++) if (mag[i]) p = i;
    if (p <= 23) return {neg, mag[30:0]};
    sh   = p - 23;
    q    = mag >> sh;
    rem  = mag - (q << sh);
    half = 300'd1 << (sh - 1);
    if (rem > half || (rem == half && q[0])) q = q + 1;
    enc = (longint'(sh + 1) << 23) + longint'(q[24:0]) - (longint'(1) << 23);
    if (enc >= (longint'(255) << 23)) return {neg, 8'hFF, 23'd0};
    return {neg, enc[30:0]};
  endfunction

  function automatic logic [31:0] randFp();
    logic [31:0] r;
    logic [31:0] specials [7];
    int sel;
    specials = '{32'h7F800000, 32'hFF800000, 32'h7FC00001, 32'h00000000,
                 32'h80000000, 32'h7F7FFFFF, 32'hFF7FFFFF};
    r   = $urandom;
    sel = int'($urandom_range(0, 31));
    if (sel == 0) r = specials[$urandom_range(0, 6)];
    else if (sel <= 4) r[30:23] = 8'd0;
    else if (sel <= 6) r[30:23] = 8'($urandom_range(250, 254));
    else if (sel <= 9) r = $urandom;
    else r[30:23] = 8'(120 + $urandom_range(0, 15));
    return r;
  endfunction

  // out_ready policy: 0 = always ready, 1 = stalled, otherwise random per cycle.
  always @(posedge clk) begin
    #1;
    case (rdyMode)
      0: out_ready = 1'b1;
      1: out_ready = 1'b0;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  logic        stallSeen = 1'b0;
  logic        takeSeen = 1'b0;
  logic [31:0] stallData = 32'd0;

  // Output monitor: scoreboards every taken result and checks hold/release behaviour.
  always @(negedge clk) begin
    if (!rst_n) begin
      stallSeen = 1'b0;
      takeSeen  = 1'b0;
    end else begin
      if (takeSeen) checkOutput("postTake", {30'd0, out_valid, in_ready}, 32'd1);
      if (stallSeen) begin
        checkOutput("holdValid", 32'(out_valid), 32'd1);
        checkOutput("holdData", out_data, stallData);
        checkOutput("holdInReady", 32'(in_ready), 32'd0);
      end
      if (out_valid && out_ready) begin
        checkOutput("pendingCount", 32'(expQ.size()), 32'd1);
        if (expQ.size() > 0) checkOutput("result", out_data, expQ.pop_front());
      end
      takeSeen  = out_valid && out_ready;
      stallSeen = out_valid && !out_ready;
      stallData = out_data;
    end
  end

  task automatic applyStimulus(input int len, input int gapMax, input int otherLen,
                               input bit hasExp, input logic [31:0] expVal);
    int n;
    int gaps;
    int waitT;
    logic [31:0] model;
    n = (len == 0) ? 1 : len;
    model = beatBuf[0];
    for (int i = 1; i < n; i++) model = refAdd(model, beatBuf[i]);
    for (int i = 0; i < n; i++) begin
      gaps = (gapMax > 0) ? int'($urandom_range(0, gapMax)) : 0;
      repeat (gaps) begin
        in_valid = 1'b0;
        in_data  = $urandom;
        acc_len  = W'($urandom);
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = beatBuf[i];
      acc_len  = (i == 0) ? W'(len) : ((otherLen < 0) ? W'($urandom) : W'(otherLen));
      waitT = 0;
      @(negedge clk);
      while (!in_ready && waitT < 300) begin
        @(negedge clk);
        waitT++;
      end
      if (!in_ready) begin
        checkOutput("beatTimeout", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (i == n - 1) begin
        expQ.push_back(hasExp ? expVal : model);
        checkOutput("validAfterLast", 32'(out_valid), 32'd1);
        checkOutput("busyAfterLast", 32'(busy), 32'd1);
      end else begin
        checkOutput("noEarlyValid", 32'(out_valid), 32'd0);
        checkOutput("busyMidGroup", 32'(busy), 32'd1);
      end
    end
  endtask

  task automatic waitDrain();
    int t;
    t = 0;
    while ((expQ.size() > 0 || busy) && t < 2000) begin
      @(posedge clk); #1;
      t++;
    end
    checkOutput("drainQueue", 32'(expQ.size()), 32'd0);
    checkOutput("drainBusy", 32'(busy), 32'd0);
  endtask

  logic [31:0] dirA [9];
  logic [31:0] dirB [9];
  logic [31:0] dirE [9];

  initial begin
    dirA = '{32'h3F800000, 32'h3F800000, 32'h7F7FFFFF, 32'h7F800000, 32'h3F800000,
             32'h80000000, 32'h00000001, 32'h7FC00000, 32'h40000000};
    dirB = '{32'h33800000, 32'h33C00000, 32'h7F7FFFFF, 32'hFF800000, 32'hBF800000,
             32'h80000000, 32'h00000001, 32'h3F800000, 32'h7F800000};
    dirE = '{32'h3F800000, 32'h3F800001, 32'h7F800000, 32'h7FC00000, 32'h00000000,
             32'h80000000, 32'h00000002, 32'h7FC00000, 32'h7F800000};

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 32'd0;
    acc_len  = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstInReady", 32'(in_ready), 32'd1);
    checkOutput("rstOutValid", 32'(out_valid), 32'd0);
    checkOutput("rstOutData", out_data, 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    beatBuf[0] = 32'h3F800000; beatBuf[1] = 32'h40000000;
    beatBuf[2] = 32'h40400000; beatBuf[3] = 32'h40800000;
    applyStimulus(4, 0, -1, 1'b1, 32'h41200000);
    waitDrain();

    for (int i = 0; i < 9; i++) begin
      beatBuf[0] = dirA[i];
      beatBuf[1] = dirB[i];
      applyStimulus(2, 0, -1, 1'b1, dirE[i]);
    end
    waitDrain();

    beatBuf[0] = 32'hC0490FDB;
    applyStimulus(0, 0, -1, 1'b1, 32'hC0490FDB);
    beatBuf[0] = 32'h3F800000; beatBuf[1] = 32'h40000000; beatBuf[2] = 32'h40400000;
    applyStimulus(3, 0, 1, 1'b1, 32'h40C00000);
    waitDrain();

    rdyMode = 1;
    beatBuf[0] = 32'h3F800000; beatBuf[1] = 32'h3F000000; beatBuf[2] = 32'h3E800000;
    applyStimulus(3, 3, -1, 1'b1, 32'h3FE00000);
    fork
      begin
        repeat (5) @(posedge clk);
        #2 rdyMode = 0;
      end
    join_none
    beatBuf[0] = 32'h40000000; beatBuf[1] = 32'h40000000;
    applyStimulus(2, 0, -1, 1'b1, 32'h40800000);
    waitDrain();

    in_valid = 1'b1;
    in_data  = 32'h3F800000;
    acc_len  = W'(4);
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("midGroupBusy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midRstInReady", 32'(in_ready), 32'd1);
    checkOutput("midRstOutValid", 32'(out_valid), 32'd0);
    checkOutput("midRstOutData", out_data, 32'd0);
    checkOutput("midRstBusy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) beatBuf[i] = 32'h3F800000;
    applyStimulus(4, 0, -1, 1'b1, 32'h40800000);
    waitDrain();

    rdyMode = 2;
    repeat (40) begin
      int len;
      len = int'($urandom_range(0, 9));
      for (int i = 0; i < 10; i++) beatBuf[i] = randFp();
      applyStimulus(len, int'($urandom_range(0, 2)), -1, 1'b0, 32'd0);
    end
    for (int i = 0; i < 255; i++) beatBuf[i] = {1'b0, 8'(100 + $urandom_range(0, 20)), 23'($urandom)};
    applyStimulus(255, 0, -1, 1'b0, 32'd0);
    waitDrain();

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete, miscompares so far %0d", missCount);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/fp_acc.md
Name: fp_acc

Overview:
- Downstream consumer of the FP16×FP16→FP32 multiplier stage.
- Accepts a stream of FP32 products over a valid/ready handshake and sums each group of N products into an FP32 accumulator, rounding every addition with RNE.
- Emits one FP32 result per group over a second valid/ready handshake.
- Forms the reduction half of a dot-product lane: multiplier → fp_acc → writeback.

Parameters:
- AccLenWidth, 8, width of the runtime group-length input; maximum group length is 2^AccLenWidth − 1.
- FpFormat, fpnew_pkg_snax::fp_format_e'(0) (FP32), operand/result format. Only FP32 is supported; elaborating any other value is an error.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- in_valid_i  in  1  product beat valid
- in_ready_o  out  1  block can accept a product beat
- in_data_i  in  32  FP32 product
- acc_len_i  in  AccLenWidth  products per group; sampled only on the first beat of a group
- out_valid_o  out  1  group sum valid
- out_ready_i  in  1  consumer accepts the sum
- out_data_o  out  32  FP32 group sum
- busy_o  out  1  a group is in progress or a result is waiting to be taken

Behaviour:
- One clock, clk_i. Reset is asynchronous and active-low on rst_ni; all state is cleared immediately on assertion.
- Reset values:
  - state = IDLE, accumulator = 0x00000000, counter = 0.
  - in_ready_o = 1, out_valid_o = 0, out_data_o = 0x00000000, busy_o = 0.
- A beat transfers when valid && ready on a rising edge. Upstream must hold in_data_i stable while in_valid_i=1 and in_ready_o=0.
- FSM IDLE:
  - in_ready_o=1.
  - On a transfer: accumulator ← in_data_i verbatim (no add, so −0 and NaN payloads are not altered yet). len ← max(acc_len_i, 1). count ← 1.
  - If len==1, go to OUT; otherwise go to ACC.
- FSM ACC:
  - in_ready_o=1, busy_o=1.
  - On a transfer: accumulator ← fp_add(accumulator, in_data_i), count ← count+1.
  - When the incremented count equals len, go to OUT.
  - No transfer means no state change, so bubbles are allowed indefinitely.
- FSM OUT:
  - in_ready_o=0, out_valid_o=1, out_data_o=accumulator, busy_o=1.
  - out_data_o stays stable until the handshake completes.
  - On out_ready_i=1, go to IDLE. The next group's first beat is accepted no earlier than the following cycle.
- Latency and throughput:
  - out_valid_o rises one cycle after the last beat transfers.
  - Best-case throughput is len+1 cycles per group.
- fp_add is single-cycle combinational, feeding the accumulator register directly. Its datapath:
  - Unpack both operands: hidden bit = (exp≠0), subnormal effective exponent = 1.
  - Swap so the larger magnitude is first, then right-shift the smaller significand by the exponent difference.
  - Keep 3 extra bits (guard, round, sticky) and OR all bits shifted beyond them into sticky; shifts ≥ 27 collapse to sticky only.
  - Add or subtract the 24+3-bit significands into a 28-bit result.
  - Normalise with a leading-zero count; the left shift is limited so the exponent never drops below 1 (subnormal output).
  - Apply RNE on guard/round/sticky; a mantissa carry-out increments the exponent.
- Special cases for fp_add:
  - Either operand NaN → 0x7FC00000.
  - +inf plus −inf → 0x7FC00000.
  - inf plus finite, or inf plus same-sign inf → that inf.
  - Exponent ≥ 255 after rounding → ±inf (0x7F800000 / 0xFF800000).
  - Exact zero from opposite-sign operands → +0. (−0)+(−0) → −0.
- Subnormals are fully supported on input and output; there is no flush-to-zero.
- Counter width is AccLenWidth. acc_len_i=0 is treated as 1.
- in_valid_i asserted during OUT is held off (in_ready_o=0), not dropped.
- Reset mid-group discards the partial sum and any pending result.
- No exception flags are produced.

Test Plan:
- Basic sum: acc_len=4; beats 0x3F800000, 0x40000000, 0x40400000, 0x40800000 back-to-back, out_ready=1 → one result 0x41200000 (10.0), with out_valid high exactly one cycle after the 4th beat.
- RNE:
  - acc_len=2, beats 0x3F800000 then 0x33800000 → 0x3F800000 (tie goes to even).
  - acc_len=2, beats 0x3F800000 then 0x33C00000 → 0x3F800001.
- Specials, one group each with acc_len=2:
  - 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000.
  - 0x7F800000 + 0xFF800000 → 0x7FC00000.
  - 0x3F800000 + 0xBF800000 → 0x00000000.
  - 0x80000000 + 0x80000000 → 0x80000000.
  - 0x00000001 + 0x00000001 → 0x00000002.
- Backpressure and bubbles: acc_len=3 with gaps between beats; hold out_ready=0 for 5 cycles.
  - out_data stays stable and in_ready=0 throughout.
  - A pending in_valid is accepted only one cycle after the out handshake.
  - Result correct; no beat lost or duplicated.
- Length edge cases:
  - acc_len=0, beat 0xC0490FDB → output 0xC0490FDB after 1 cycle.
  - acc_len changed mid-group from 3 to 1 → the group still takes 3 beats.
- Reset mid-operation: assert rst_ni low after 2 of 4 beats → outputs return to reset values immediately. A new group of 4 × 0x3F800000 then yields 0x40800000.
